// File: rtl/host_tx_arbiter.sv
// host_tx_arbiter
//
// Packet-atomic round-robin arbiter. It merges N_SRC AXI-stream byte sources
// onto the single host byte stream. A grant is held from a packet's first beat
// through its tlast beat, so packets from different sources never interleave.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   s_tdata/tvalid/tlast/tready   per-source streams (source i at [i*DATA_W +: DATA_W])
//   m_tdata/tvalid/tlast/tready   merged stream towards the to-host FIFO
//   grant_vld, grant_idx          link ownership (idx holds its value when not granted)
//   abort_pulse                   one cycle when the stall watchdog fires
//
// Build option: define HOST_TX_ARB_WATCHDOG_EN to compile in the stall watchdog
// and the ABORT state. Without it abort_pulse is tied low and a stalled
// granted source keeps the link indefinitely.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; arbitrate among valid sources from rr_ptr upward
// BUSY  | one source granted; its stream is muxed straight through
// ABORT | emitting the single ABORT_BYTE terminator (watchdog only)

module host_tx_arbiter #(
    parameter int                 N_SRC      = 2,
    parameter int                 DATA_W     = 8,
    parameter int                 TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0]  ABORT_BYTE = DATA_W'(8'hFF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_SRC*DATA_W-1:0]     s_tdata,
    input  logic [N_SRC-1:0]            s_tvalid,
    input  logic [N_SRC-1:0]            s_tlast,
    output logic [N_SRC-1:0]            s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic                        grant_vld,
    output logic [$clog2(N_SRC)-1:0]    grant_idx,
    output logic                        abort_pulse
);

    localparam int IW = $clog2(N_SRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef HOST_TX_ARB_WATCHDOG_EN
        ST_ABORT = 2'd2,
`endif
        ST_BUSY  = 2'd1
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      grant_idx_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      rr_ptr_d;
    logic               grant_vld_q;

    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic [IW-1:0]      cand;
    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic               busy;
    logic               beat;

    assign busy    = (state_q == ST_BUSY);
    assign g_valid = s_tvalid[grant_idx_q];
    assign g_last  = s_tlast[grant_idx_q];
    assign g_data  = s_tdata[grant_idx_q*DATA_W +: DATA_W];
    assign beat    = busy && g_valid && m_tready;

    // Source that just held the link becomes lowest priority; explicit wrap
    // keeps the pointer inside 0..N_SRC-1 for non power-of-two N_SRC.
    assign rr_ptr_d = (grant_idx_q == IW'(N_SRC - 1)) ? '0 : grant_idx_q + 1'b1;

    // First valid source at or after rr_ptr, scanning upward modulo N_SRC.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % N_SRC);
            if (!pick_vld && s_tvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

`ifdef HOST_TX_ARB_WATCHDOG_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        wdog_fire;
    logic        in_abort;

    assign in_abort  = (state_q == ST_ABORT);
    assign cnt_d     = cnt_q + 16'd1;
    // Fires on the stalled cycle that brings the count to TIMEOUT.
    assign wdog_fire = busy && !g_valid && (cnt_d == 16'(TIMEOUT));
    assign abort_pulse = wdog_fire;
`else
    logic in_abort;
    logic unused_cfg;

    assign in_abort    = 1'b0;
    assign abort_pulse = 1'b0;
    assign unused_cfg  = ^{ABORT_BYTE, 32'(TIMEOUT)};
`endif

    always_comb begin
        s_tready = '0;
        if (busy) begin
            s_tready[grant_idx_q] = m_tready;
        end
    end

    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        if (busy) begin
            m_tdata  = g_data;
            m_tvalid = g_valid;
            m_tlast  = g_last;
        end else if (in_abort) begin
            m_tdata  = ABORT_BYTE;
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
        end
    end

    assign grant_vld = grant_vld_q;
    assign grant_idx = grant_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            grant_vld_q <= 1'b0;
`ifdef HOST_TX_ARB_WATCHDOG_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q     <= ST_BUSY;
                        grant_idx_q <= pick_idx;
                        grant_vld_q <= 1'b1;
`ifdef HOST_TX_ARB_WATCHDOG_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef HOST_TX_ARB_WATCHDOG_EN
                    // Downstream back-pressure (valid high, ready low) holds the count.
                    if (beat) begin
                        cnt_q <= '0;
                    end else if (!g_valid) begin
                        cnt_q <= cnt_d;
                    end
`endif
                    if (beat && g_last) begin
                        state_q     <= ST_IDLE;
                        rr_ptr_q    <= rr_ptr_d;
                        grant_vld_q <= 1'b0;
                    end
`ifdef HOST_TX_ARB_WATCHDOG_EN
                    else if (wdog_fire) begin
                        state_q <= ST_ABORT;
                    end
`endif
                end
`ifdef HOST_TX_ARB_WATCHDOG_EN
                ST_ABORT: begin
                    if (m_tready) begin
                        state_q     <= ST_IDLE;
                        rr_ptr_q    <= rr_ptr_d;
                        grant_vld_q <= 1'b0;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_tx_arbiter.sv
module tb_host_tx_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Two-source DUT
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid, s_tlast, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic        grant_vld;
    logic [0:0]  grant_idx;
    logic        abort_pulse;

    // Three-source DUT
    logic [23:0] t_tdata;
    logic [2:0]  t_tvalid, t_tlast, t_tready;
    logic [7:0]  t_mdata;
    logic        t_mvalid, t_mlast, t_mready;
    logic        t_gvld;
    logic [1:0]  t_gidx;
    logic        t_abort;

    host_tx_arbiter #(.N_SRC(2), .DATA_W(8), .TIMEOUT(8), .ABORT_BYTE(8'hFF)) u0 (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_vld(grant_vld), .grant_idx(grant_idx), .abort_pulse(abort_pulse)
    );

    host_tx_arbiter #(.N_SRC(3), .DATA_W(8)) u3 (
        .clk(clk), .reset(reset),
        .s_tdata(t_tdata), .s_tvalid(t_tvalid), .s_tlast(t_tlast), .s_tready(t_tready),
        .m_tdata(t_mdata), .m_tvalid(t_mvalid), .m_tlast(t_mlast), .m_tready(t_mready),
        .grant_vld(t_gvld), .grant_idx(t_gidx), .abort_pulse(t_abort)
    );

    int vectors = 0;
    int errors  = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];
    logic en0 = 1'b1;
    logic en1 = 1'b1;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        s_tvalid[0]  = en0 && (q0.size() > 0);
        s_tdata[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        s_tlast[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
        s_tvalid[1]  = en1 && (q1.size() > 0);
        s_tdata[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        s_tlast[1]   = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic monitor();
        logic [8:0] e;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'hDEADBEEF);
            end else begin
                e = exp_q.pop_front();
                chk("m_tdata", 32'(m_tdata), 32'(e[7:0]));
                chk("m_tlast", 32'(m_tlast), 32'(e[8]));
            end
        end
    endtask

    // Called at a negedge: capture handshakes, cross the posedge, update
    // the source models, then settle to the next negedge and score output.
    task automatic edge_t(input logic rdy);
        logic f0, f1;
        f0 = s_tvalid[0] & s_tready[0];
        f1 = s_tvalid[1] & s_tready[1];
        @(posedge clk);
        #1;
        if (f0 && q0.size() > 0) void'(q0.pop_front());
        if (f1 && q1.size() > 0) void'(q1.pop_front());
        m_tready = rdy;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input int bound, output int cnt);
        cnt = 0;
        while (exp_q.size() > 0 && cnt < bound) begin
            edge_t(1'b1);
            cnt++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        t_tdata = '0; t_tvalid = '0; t_tlast = '0; t_mready = 1'b1;

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_abort", 32'(abort_pulse), 32'd0);
        chk("rst_u3_gvld", 32'(t_gvld), 32'd0);
        reset = 1'b0;

        // 3-beat packet on source 0
        q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133);
        exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
        drive();
        chk("t1_c0_gvld", 32'(grant_vld), 32'd0);
        chk("t1_c0_mvalid", 32'(m_tvalid), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            edge_t(1'b1);
            chk("t1_gvld", 32'(grant_vld), (c <= 3) ? 32'd1 : 32'd0);
            chk("t1_mvalid", 32'(m_tvalid), (c <= 3) ? 32'd1 : 32'd0);
        end
        chk("t1_left", 32'(exp_q.size()), 32'd0);

        // Both sources stream 2-beat packets: strict alternation, one bubble each
        reset = 1'b1; edge_t(1'b1); reset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            q0.push_back(9'h0A0); q0.push_back(9'h1A1);
            q1.push_back(9'h0B0); q1.push_back(9'h1B1);
            exp_q.push_back(9'h0A0); exp_q.push_back(9'h1A1);
            exp_q.push_back(9'h0B0); exp_q.push_back(9'h1B1);
        end
        drive();
        drain(60, n);
        chk("t2_cycles", 32'(n), 32'd17);

        // Source 1 mid-packet with toggling m_tready; source 0 valid wiggles
        en0 = 1'b0;
        q1.push_back(9'h0C0); q1.push_back(9'h0C1); q1.push_back(9'h0C2); q1.push_back(9'h1C3);
        q0.push_back(9'h1D0);
        exp_q.push_back(9'h0C0); exp_q.push_back(9'h0C1); exp_q.push_back(9'h0C2);
        exp_q.push_back(9'h1C3); exp_q.push_back(9'h1D0);
        drive();
        edge_t(1'b1);
        edge_t(1'b0);
        chk("t3_gidx", 32'(grant_idx), 32'd1);
        for (int i = 0; i < 30 && exp_q.size() > 1; i++) begin
            en0 = i[0];
            edge_t(i % 2 == 0);
            chk("t3_s_tready0", 32'(s_tready[0]), 32'd0);
            chk("t3_s_tready1", 32'(s_tready[1]), 32'(m_tready));
        end
        en0 = 1'b1;
        drive();
        drain(10, n);

        // Reset in the middle of a source-1 packet
        reset = 1'b1; edge_t(1'b1); reset = 1'b0;
        q1.push_back(9'h0E0); q1.push_back(9'h0E1); q1.push_back(9'h1E2);
        exp_q.push_back(9'h0E0);
        drive();
        edge_t(1'b1);
        chk("t4_gidx", 32'(grant_idx), 32'd1);
        edge_t(1'b0);
        reset = 1'b1;
        edge_t(1'b0);
        chk("t4_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t4_m_tdata", 32'(m_tdata), 32'd0);
        chk("t4_m_tlast", 32'(m_tlast), 32'd0);
        chk("t4_s_tready", 32'(s_tready), 32'd0);
        chk("t4_gvld", 32'(grant_vld), 32'd0);
        chk("t4_gidx_rst", 32'(grant_idx), 32'd0);
        reset = 1'b0;
        q1.delete();
        q0.push_back(9'h1F0); q1.push_back(9'h1C5);
        exp_q.push_back(9'h1F0); exp_q.push_back(9'h1C5);
        drive();
        edge_t(1'b1);
        chk("t4_post_gvld", 32'(grant_vld), 32'd1);
        chk("t4_post_gidx", 32'(grant_idx), 32'd0);
        drain(10, n);

        // Three sources, only 0 and 2 requesting, pointer wraps 2 -> 0
        t_tdata = {8'h00, 8'h00, 8'h30}; t_tvalid = 3'b001; t_tlast = 3'b001;
        edge_t(1'b1);
        chk("t5_c1_gidx", 32'(t_gidx), 32'd0);
        chk("t5_c1_data", 32'(t_mdata), 32'h30);
        edge_t(1'b1);
        chk("t5_c2_gvld", 32'(t_gvld), 32'd0);
        t_tdata = {8'h52, 8'h00, 8'h31}; t_tvalid = 3'b101; t_tlast = 3'b101;
        edge_t(1'b1);
        chk("t5_c3_gidx", 32'(t_gidx), 32'd2);
        chk("t5_c3_data", 32'(t_mdata), 32'h52);
        chk("t5_c3_ready", 32'(t_tready), 32'b100);
        edge_t(1'b1);
        chk("t5_c4_gvld", 32'(t_gvld), 32'd0);
        t_tdata[23:16] = 8'h53;
        edge_t(1'b1);
        chk("t5_c5_gidx", 32'(t_gidx), 32'd0);
        chk("t5_c5_data", 32'(t_mdata), 32'h31);
        edge_t(1'b1);
        t_tvalid = 3'b100;
        edge_t(1'b1);
        chk("t5_c7_gidx", 32'(t_gidx), 32'd2);
        chk("t5_c7_data", 32'(t_mdata), 32'h53);
        edge_t(1'b1);
        t_tvalid = 3'b000;
        chk("t5_c8_gvld", 32'(t_gvld), 32'd0);

        // Stall of the granted source
        reset = 1'b1; edge_t(1'b1); reset = 1'b0;
`ifdef HOST_TX_ARB_WATCHDOG_EN
        q0.push_back(9'h001); q1.push_back(9'h177);
        exp_q.push_back(9'h001); exp_q.push_back(9'h1FF); exp_q.push_back(9'h177);
        drive();
        for (int c = 1; c <= 12; c++) begin
            edge_t(1'b1);
            chk("t6_abort", 32'(abort_pulse), (c == 9) ? 32'd1 : 32'd0);
            if (c == 10) chk("t6_abort_ready", 32'(s_tready), 32'd0);
            if (c == 12) chk("t6_gidx", 32'(grant_idx), 32'd1);
        end
        chk("t6_left", 32'(exp_q.size()), 32'd0);
`else
        q0.push_back(9'h001);
        exp_q.push_back(9'h001);
        drive();
        for (int c = 1; c <= 20; c++) begin
            edge_t(1'b1);
            chk("t6_abort_off", 32'(abort_pulse), 32'd0);
        end
        chk("t6_hold_gvld", 32'(grant_vld), 32'd1);
        chk("t6_hold_gidx", 32'(grant_idx), 32'd0);
        chk("t6_left", 32'(exp_q.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/host_tx_arbiter.md
# host_tx_arbiter

Packet-atomic round-robin arbiter that shares the single outgoing host byte stream (the path into the to-host FIFO and the FT245 bridge) between N_SRC AXI-stream byte sources, such as the core's event output and a status/debug responder. A grant is held from a packet's first beat through its `tlast` beat, so packets from different sources never interleave on the host link. An optional stall watchdog can abort a packet that stalls mid-stream.

## Interface
- `N_SRC`, 2: number of requesting sources, 2..8.
- `DATA_W`, 8: byte-stream width.
- `TIMEOUT`, 1024: stall-watchdog limit in cycles. Used only with the watchdog compiled in.
- `ABORT_BYTE`, 8'hFF: terminator byte emitted on a watchdog abort.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `s_tdata`  in  N_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid`  in  N_SRC  per-source valid.
- `s_tlast`  in  N_SRC  per-source end-of-packet.
- `s_tready`  out  N_SRC  per-source ready.
- `m_tdata`  out  DATA_W  merged stream to the outgoing FIFO.
- `m_tvalid`  out  1  merged valid.
- `m_tlast`  out  1  merged end-of-packet.
- `m_tready`  in  1  downstream ready.
- `grant_vld`  out  1  a source currently holds the link.
- `grant_idx`  out  $clog2(N_SRC)  index of the granted source; held at its last value when `grant_vld`=0.
- `abort_pulse`  out  1  one-cycle pulse when the watchdog fires; tied 0 when the watchdog is compiled out.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one source granted.
  - ABORT: emitting the terminator byte (exists only with the watchdog compiled in).
- IDLE:
  - All `s_tready`=0 and `m_tvalid`=0.
  - If any `s_tvalid` is set, grant the first index at or after `rr_ptr`, scanning upward modulo N_SRC.
  - Set `grant_idx`; `grant_vld`=1; go to BUSY.
- BUSY, pass-through (combinational from the granted source):
  - `m_tdata`/`m_tvalid`/`m_tlast` = source g's `tdata`/`tvalid`/`tlast`.
  - `s_tready[g]` = `m_tready`; all other `s_tready` = 0.
- Leaving BUSY:
  - Trigger: a beat with `s_tvalid[g] & m_tready & s_tlast[g]`.
  - Next state IDLE; `rr_ptr` = (g+1) mod N_SRC; `grant_vld`=0.
- Fairness: a source that held the link is lowest priority at the next arbitration. A continuously requesting source waits at most N_SRC-1 packets.
- Non-granted sources: valid may rise or fall freely, with no effect until arbitration.
- `rr_ptr` width is $clog2(N_SRC) and it wraps at N_SRC. It must not index past N_SRC-1 when N_SRC is not a power of two.
- Reset mid-packet:
  - State returns to IDLE, `rr_ptr`=0, all outputs deasserted.
  - The partial packet is not terminated. Upstream and downstream FIFOs are reset by the same `reset`.

## Timing
- Reset values: `s_tready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `grant_vld`=0, `grant_idx`=0, `abort_pulse`=0.
- Arbitration: one bubble cycle. A request seen in IDLE at cycle t is granted with `grant_vld`=1 from t+1; its first beat can transfer at t+1.
- Packet boundaries: one bubble cycle after every `tlast` beat (the IDLE cycle). Single-beat packets therefore sustain at most 50 % throughput.
- Within a packet: zero added latency; back-to-back beats at full rate.
- Outputs are registered state; data/valid/ready paths are combinational muxes of the granted source.
- A `tlast` beat and a new request from another source in the same cycle: the new grant starts at the following IDLE cycle; the freshly advanced `rr_ptr` is used.

## Configuration
- `HOST_TX_ARB_WATCHDOG_EN` defined:
  - In BUSY, a 16-bit counter increments on every cycle with `s_tvalid[g]`=0. It clears on any accepted beat and on grant.
  - When the counter reaches `TIMEOUT`: pulse `abort_pulse` for one cycle and enter ABORT.
  - ABORT: drive `m_tvalid`=1, `m_tdata`=`ABORT_BYTE`, `m_tlast`=1, all `s_tready`=0.
  - When that beat is accepted, go to IDLE with `rr_ptr`=(g+1) mod N_SRC.
  - The aborted source's later bytes are arbitrated as a new packet.
  - Downstream stalls (`m_tready`=0) never advance the counter.
- Undefined: no counter and no ABORT state; `abort_pulse` tied 0; a stalled granted source holds the link indefinitely.

## Test plan
- Reset, then a 3-beat packet 0x11,0x22,0x33(last) on source 0 with `m_tready`=1 -> `grant_vld` at cycle 1, bytes on m at cycles 1-3, `m_tlast` on 0x33, IDLE at cycle 4.
- Both sources continuously send 2-beat packets (src0 0xA0,0xA1; src1 0xB0,0xB1) -> output order A0 A1 B0 B1 A0 A1 …, never interleaved, one bubble between packets.
- Source 1 mid-packet while `m_tready` toggles 1,0,1,0 -> bytes accepted only on ready cycles, no loss or duplication; `s_tready[0]` stays 0 throughout.
- N_SRC=3, only sources 0 and 2 requesting, `rr_ptr`=1 -> source 2 granted first, then 0; `rr_ptr` wraps from 2 to 0.
- Watchdog on, `TIMEOUT`=8: source 0 sends 0x01 then deasserts valid -> `abort_pulse` 8 cycles after the 0x01 beat, then 0xFF with `m_tlast`=1, then source 1's pending packet is granted.
- Reset asserted mid-packet on source 1 -> next cycle all outputs 0 and `grant_vld`=0; the first request after reset is granted from index 0.
